// File: rtl/nis_cpu_uart_onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : nis_cpu_uart_onchip_mem_arbiter_if
// Purpose  : One Avalon-MM master link (word address, byte enables, read/write
//            strobes, write data, waitrequest, pipelined read return) between
//            a master and the on-chip memory arbiter.
// Modports : master - the requesting side (drives address/strobes/data)
//            slave  - the arbiter side (drives waitrequest/readdata/valid)
// Revision : 1.0 - initial release
// ============================================================================
interface nis_cpu_uart_onchip_mem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface
`default_nettype wire

// File: rtl/nis_cpu_uart_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nis_cpu_uart_onchip_mem_arbiter
// Purpose  : Shares the single-port on-chip RAM between the Nios data master
//            (m0) and the UART loader/DMA master (m1). Round-robin grant per
//            access, pipelined read-return tagging, out-of-range filtering
//            and freeze gating.
// Ports    : clk, reset (sync, active-high), freeze (blocks new grants)
//            m0, m1          - master links (slave modport)
//            mem_*           - RAM s1 port (address/be/cs/write/wdata/clken/q)
//            oor_error       - sticky out-of-range access flag
// Revision : 1.0 - initial release
// ============================================================================
module nis_cpu_uart_onchip_mem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2500
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  freeze,
   nis_cpu_uart_onchip_mem_arbiter_if.slave m0,
   nis_cpu_uart_onchip_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata,
   output logic                  oor_error
);

   // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   logic                req0, req1;
   logic                grant_ok, grant0, grant1, any_grant;
   logic [ADDR_W-1:0]   win_address;
   logic                win_write;
   logic                win_in_range;

   logic                last_grant_m1;   // 1: m1 holds the last grant
   logic [1:0]          rd_pend;         // read-return tag, one bit per master
   logic                rd_oor;          // tagged read was out of range

   // A simultaneous read+write counts as a write: only the write strobe
   // decides the direction below.
   assign req0 = m0.read | m0.write;
   assign req1 = m1.read | m1.write;

   // Under contention the master that did not win last time goes next.
   assign grant_ok  = ~freeze & ~reset;
   assign grant0    = grant_ok & req0 & (~req1 |  last_grant_m1);
   assign grant1    = grant_ok & req1 & (~req0 | ~last_grant_m1);
   assign any_grant = grant0 | grant1;

   assign m0.waitrequest = req0 & ~grant0;
   assign m1.waitrequest = req1 & ~grant1;

   // With no grant the m0 values pass through; chipselect masks them.
   assign win_address    = grant1 ? m1.address    : m0.address;
   assign mem_address    = win_address;
   assign mem_byteenable = grant1 ? m1.byteenable : m0.byteenable;
   assign mem_writedata  = grant1 ? m1.writedata  : m0.writedata;
   assign win_write      = grant1 ? m1.write      : m0.write;
   assign win_in_range   = {1'b0, win_address} < DEPTH_LIM;

   // Out-of-range accesses are granted but never reach the RAM.
   assign mem_chipselect = any_grant & win_in_range;
   assign mem_write      = mem_chipselect & win_write;
   assign mem_clken      = 1'b1;

   // Gating with reset discards a tag issued the cycle before reset.
   assign m0.readdatavalid = rd_pend[0] & ~reset;
   assign m1.readdatavalid = rd_pend[1] & ~reset;
   assign m0.readdata = (m0.readdatavalid & ~rd_oor) ? mem_readdata : '0;
   assign m1.readdata = (m1.readdatavalid & ~rd_oor) ? mem_readdata : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend       <= 2'b00;
         rd_oor        <= 1'b0;
         last_grant_m1 <= 1'b1;
         oor_error     <= 1'b0;
      end else begin
         rd_pend <= {grant1 & ~m1.write, grant0 & ~m0.write};
         rd_oor  <= ~win_in_range;
         if (any_grant) begin
            last_grant_m1 <= grant1;
         end
         if (any_grant & ~win_in_range) begin
            oor_error <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nis_cpu_uart_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nis_cpu_uart_onchip_mem_arbiter
// Purpose  : Self-checking bench: directed scenarios with literal expectations
//            followed by randomized traffic compared every cycle against a
//            transaction-level reference model (winner choice, expected read
//            return queue, shadow memory, sticky error flag).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nis_cpu_uart_onchip_mem_arbiter;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2500;

   logic clk = 1'b0;
   logic reset;
   logic freeze;
   always #5 clk = ~clk;

   nis_cpu_uart_onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
   nis_cpu_uart_onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

   logic [11:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken, oor_error;
   logic [31:0] mem_writedata, mem_readdata;

   nis_cpu_uart_onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .freeze(freeze),
      .m0(m0_if), .m1(m1_if),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata), .oor_error(oor_error)
   );

   // RAM stand-in: byte-enabled write, registered read of the presented address.
   logic [31:0] ram [0:4095];
   always @(posedge clk) begin
      if (mem_chipselect && mem_write) begin
         for (int b = 0; b < 4; b++)
            if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end
      mem_readdata <= ram[mem_address];
   end

   // ---------------- reference model ----------------
   typedef struct { int who; logic [31:0] data; int due; } ret_t;
   ret_t        pend_q[$];
   logic [31:0] ref_mem [0:DEPTH-1];
   int          last_win, cyc, errors, checks, win;
   logic        exp_oor, rst_now, w_wr, w_inr;
   logic [11:0] w_addr;
   logic [3:0]  w_be;
   logic [31:0] w_data;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Evaluate the current cycle at the falling edge and compare.
   task automatic half_a();
      logic r0, r1, ev0, ev1;
      logic [31:0] ed0, ed1;
      @(negedge clk);
      r0 = m0_if.read | m0_if.write;
      r1 = m1_if.read | m1_if.write;
      rst_now = reset;
      if (reset || freeze)  win = -1;
      else if (r0 && r1)    win = 1 - last_win;
      else if (r0)          win = 0;
      else if (r1)          win = 1;
      else                  win = -1;
      ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0;
      if (!reset) begin
         foreach (pend_q[i]) begin
            if (pend_q[i].due == cyc) begin
               if (pend_q[i].who == 0) begin ev0 = 1; ed0 = pend_q[i].data; end
               else                    begin ev1 = 1; ed1 = pend_q[i].data; end
            end
         end
      end
      chk("m0_waitrequest", m0_if.waitrequest, r0 && win != 0);
      chk("m1_waitrequest", m1_if.waitrequest, r1 && win != 1);
      w_addr = (win == 1) ? m1_if.address    : m0_if.address;
      w_be   = (win == 1) ? m1_if.byteenable : m0_if.byteenable;
      w_data = (win == 1) ? m1_if.writedata  : m0_if.writedata;
      w_wr   = (win == 1) ? m1_if.write      : m0_if.write;
      w_inr  = int'(w_addr) < DEPTH;
      chk("mem_chipselect", mem_chipselect, win >= 0 && w_inr);
      chk("mem_write", mem_write, win >= 0 && w_inr && w_wr);
      if (win >= 0 && w_inr) begin
         chk("mem_address", mem_address, w_addr);
         chk("mem_byteenable", mem_byteenable, w_be);
         if (w_wr) chk("mem_writedata", mem_writedata, w_data);
      end
      chk("m0_readdatavalid", m0_if.readdatavalid, ev0);
      chk("m0_readdata", m0_if.readdata, ed0);
      chk("m1_readdatavalid", m1_if.readdatavalid, ev1);
      chk("m1_readdata", m1_if.readdata, ed1);
      chk("oor_error", oor_error, exp_oor);
      chk("mem_clken", mem_clken, 1'b1);
   endtask

   // Advance the model across the rising edge, then step off it.
   task automatic half_b();
      @(posedge clk);
      if (rst_now) begin
         pend_q.delete();
         last_win = 1;
         exp_oor  = 0;
      end else begin
         while (pend_q.size() > 0 && pend_q[0].due <= cyc) void'(pend_q.pop_front());
         if (win >= 0) begin
            last_win = win;
            if (!w_inr) exp_oor = 1;
            if (w_wr) begin
               if (w_inr)
                  for (int b = 0; b < 4; b++)
                     if (w_be[b]) ref_mem[w_addr][b*8 +: 8] = w_data[b*8 +: 8];
            end else begin
               pend_q.push_back('{win, w_inr ? ref_mem[w_addr] : 32'h0, cyc + 1});
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic cycle();
      half_a();
      half_b();
   endtask

   task automatic drive(int n, logic rd, logic wr, logic [11:0] a, logic [3:0] be, logic [31:0] d);
      if (n == 0) begin
         m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
         m0_if.byteenable = be; m0_if.writedata = d;
      end else begin
         m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
         m1_if.byteenable = be; m1_if.writedata = d;
      end
   endtask

   task automatic rand_master(int n);
      int op;
      logic [11:0] a;
      op = int'($urandom_range(0, 7));
      a  = ($urandom_range(0, 19) == 0) ? 12'($urandom_range(2500, 4095))
                                         : 12'($urandom_range(0, 15));
      drive(n, op >= 2 && op != 5 && op != 6, op >= 5, a,
            4'($urandom_range(0, 15)), $urandom());
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
      errors = 0; checks = 0; cyc = 0; last_win = 1; exp_oor = 0; win = -1;
      reset = 1; freeze = 0;
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);

      // Reset state, then both requesting while in reset.
      half_a();
      chk("rst_cs", mem_chipselect, 1'b0);
      chk("rst_rdv", m0_if.readdatavalid, 1'b0);
      chk("rst_oor", oor_error, 1'b0);
      half_b();
      drive(0, 1, 0, 12'd1, 4'hF, 0);
      drive(1, 1, 0, 12'd2, 4'hF, 0);
      half_a();
      chk("rst_wait0", m0_if.waitrequest, 1'b1);
      chk("rst_wait1", m1_if.waitrequest, 1'b1);
      half_b();
      reset = 0;

      // Continuous contention straight out of reset: m0 first, then alternate.
      for (int i = 0; i < 5; i++) begin
         half_a();
         chk("alt_wait0", m0_if.waitrequest, (i % 2) == 1);
         chk("alt_wait1", m1_if.waitrequest, (i % 2) == 0);
         if (i >= 1) begin
            chk("alt_rdv0", m0_if.readdatavalid, (i % 2) == 1);
            chk("alt_rdv1", m1_if.readdatavalid, (i % 2) == 0);
         end
         half_b();
      end
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      cycle();

      // Write then read back on m0.
      drive(0, 0, 1, 12'd5, 4'hF, 32'hDEADBEEF);
      half_a(); chk("t1_wr_wait", m0_if.waitrequest, 1'b0); half_b();
      drive(0, 1, 0, 12'd5, 4'hF, 0);
      half_a(); chk("t1_rd_wait", m0_if.waitrequest, 1'b0); half_b();
      drive(0, 0, 0, 0, 0, 0);
      half_a();
      chk("t1_rdv", m0_if.readdatavalid, 1'b1);
      chk("t1_data", m0_if.readdata, 32'hDEADBEEF);
      half_b();

      // Partial byte write by m1 over a known word.
      drive(0, 0, 1, 12'd10, 4'hF, 32'hAAAAAAAA); cycle();
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 12'd10, 4'b0010, 32'h11223344); cycle();
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 12'd10, 4'hF, 0); cycle();
      drive(0, 0, 0, 0, 0, 0);
      half_a(); chk("t3_data", m0_if.readdata, 32'hAAAA33AA); half_b();

      // Out-of-range write and read.
      drive(0, 0, 1, 12'd2500, 4'hF, 32'h12345678);
      half_a(); chk("t4_wr_cs", mem_chipselect, 1'b0); chk("t4_wr_wait", m0_if.waitrequest, 1'b0); half_b();
      drive(0, 1, 0, 12'd4095, 4'hF, 0);
      half_a(); chk("t4_rd_cs", mem_chipselect, 1'b0); chk("t4_oor_set", oor_error, 1'b1); half_b();
      drive(0, 0, 0, 0, 0, 0);
      half_a();
      chk("t4_rdv", m0_if.readdatavalid, 1'b1);
      chk("t4_data", m0_if.readdata, 32'h0);
      half_b();
      cycle(); cycle();

      // Freeze holds off m1 for three cycles.
      freeze = 1;
      drive(1, 1, 0, 12'd7, 4'hF, 0);
      for (int i = 0; i < 3; i++) begin
         half_a(); chk("t5_wait", m1_if.waitrequest, 1'b1); chk("t5_cs", mem_chipselect, 1'b0); half_b();
      end
      freeze = 0;
      half_a(); chk("t5_go_wait", m1_if.waitrequest, 1'b0); chk("t5_go_cs", mem_chipselect, 1'b1); half_b();
      drive(1, 0, 0, 0, 0, 0);
      cycle();

      // Reset right after a read grant discards the return.
      drive(0, 1, 0, 12'd5, 4'hF, 0); cycle();
      drive(0, 0, 0, 0, 0, 0);
      reset = 1;
      half_a(); chk("t6_rdv", m0_if.readdatavalid, 1'b0); half_b();
      cycle();
      reset = 0;
      drive(0, 1, 0, 12'd3, 4'hF, 0);
      drive(1, 1, 0, 12'd4, 4'hF, 0);
      half_a(); chk("t6_wait0", m0_if.waitrequest, 1'b0); chk("t6_wait1", m1_if.waitrequest, 1'b1); half_b();
      cycle();

      // Randomized traffic; stalled masters hold their request.
      for (int k = 0; k < 2000; k++) begin
         logic s0, s1;
         s0 = (m0_if.read | m0_if.write) && win != 0;
         s1 = (m1_if.read | m1_if.write) && win != 1;
         if (!s0) rand_master(0);
         if (!s1) rand_master(1);
         reset  = ($urandom_range(0, 99) == 0);
         freeze = ($urandom_range(0, 9) == 0);
         cycle();
      end
      reset = 0; freeze = 0;
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      cycle(); cycle(); cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
